// File: rtl/uc_pkg.sv
// Shared state encodings, condition selectors and flag bit positions
// for the conditional-jump issue logic.
package uc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RESOLVE = 2'd3
    } cjmp_state_e;

    localparam logic [2:0] COND_ALWAYS = 3'd0;
    localparam logic [2:0] COND_Z      = 3'd1;
    localparam logic [2:0] COND_NZ     = 3'd2;
    localparam logic [2:0] COND_C      = 3'd3;
    localparam logic [2:0] COND_NC     = 3'd4;
    localparam logic [2:0] COND_N      = 3'd5;
    localparam logic [2:0] COND_NN     = 3'd6;
    localparam logic [2:0] COND_V      = 3'd7;

    localparam int unsigned FLAG_Z = 0;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_N = 2;
    localparam int unsigned FLAG_V = 3;

endpackage

// File: rtl/uc_cond_eval.sv
// Combinational jump-condition decode: selects one ALU flag (or its
// inverse, or constant true) according to cond_code.
module uc_cond_eval
    import uc_pkg::*;
(
    input  logic [2:0] cond_code,
    input  logic [3:0] flags,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        case (cond_code)
            COND_ALWAYS: taken = 1'b1;
            COND_Z:      taken = flags[FLAG_Z];
            COND_NZ:     taken = ~flags[FLAG_Z];
            COND_C:      taken = flags[FLAG_C];
            COND_NC:     taken = ~flags[FLAG_C];
            COND_N:      taken = flags[FLAG_N];
            COND_NN:     taken = ~flags[FLAG_N];
            COND_V:      taken = flags[FLAG_V];
            default:     taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/uc_cjmp_issue.sv
// Conditional-jump issue sequencer: accepts a cjmp, arms the hold counter,
// waits out the hold (or times out), then redirects the PC if taken.
module uc_cjmp_issue
    import uc_pkg::*;
#(
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned HOLD_TIMEOUT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    input  logic              instr_is_cjmp,
    input  logic [2:0]        cond_code,
    input  logic [3:0]        flags,
    input  logic [ADDR_W-1:0] jmp_target,
    input  logic              hold_in,
    output logic              cjmp_req,
    output logic              fetch_en,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_target,
    output logic              flush,
    output logic              busy,
    output logic              hold_err
);

    localparam int unsigned CNT_W = $clog2(HOLD_TIMEOUT + 1);

    cjmp_state_e       state;
    logic              taken_q;
    logic [ADDR_W-1:0] target_q;
    logic              seen_hold;
    logic [CNT_W-1:0]  wait_cnt;
    logic              cond_taken;
    logic              accept;
    logic              timeout;
    logic              wait_done;

    uc_cond_eval u_cond_eval (
        .cond_code (cond_code),
        .flags     (flags),
        .taken     (cond_taken)
    );

    assign accept    = instr_valid & instr_is_cjmp;
    // Last permitted WAIT cycle without any sign of hold.
    assign timeout   = ~seen_hold & ~hold_in & (wait_cnt == CNT_W'(HOLD_TIMEOUT - 1));
    assign wait_done = (seen_hold & ~hold_in) | timeout;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            taken_q   <= 1'b0;
            target_q  <= '0;
            seen_hold <= 1'b0;
            wait_cnt  <= '0;
            cjmp_req  <= 1'b0;
            fetch_en  <= 1'b1;
            pc_load   <= 1'b0;
            pc_target <= '0;
            flush     <= 1'b0;
            busy      <= 1'b0;
            hold_err  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    fetch_en <= 1'b1;
                    busy     <= 1'b0;
                    if (accept) begin
                        // Flags are captured here only; later changes are irrelevant.
                        taken_q   <= cond_taken;
                        target_q  <= jmp_target;
                        seen_hold <= 1'b0;
                        wait_cnt  <= '0;
                        cjmp_req  <= 1'b1;
                        fetch_en  <= 1'b0;
                        busy      <= 1'b1;
                        state     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    cjmp_req <= 1'b0;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (hold_in) begin
                        seen_hold <= 1'b1;
                    end
                    if (!seen_hold && !hold_in && wait_cnt != CNT_W'(HOLD_TIMEOUT)) begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                    if (wait_done) begin
                        pc_load <= taken_q;
                        flush   <= taken_q;
                        if (taken_q) begin
                            pc_target <= target_q;
                        end
                        if (timeout) begin
                            hold_err <= 1'b1;
                        end
                        state <= ST_RESOLVE;
                    end
                end
                ST_RESOLVE: begin
                    pc_load  <= 1'b0;
                    flush    <= 1'b0;
                    fetch_en <= 1'b1;
                    busy     <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/uc_cjmp_issue.md
UC_CJMP_ISSUE -- requirements
Module: uc_cjmp_issue

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, giving the jump target and PC width.
REQ-002 SHALL have parameter HOLD_TIMEOUT, default 4, giving the max cycles to wait for hold assertion.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port instr_valid  input  1  decoded instruction valid this cycle.
REQ-006 SHALL have port instr_is_cjmp  input  1  decoded instruction is a conditional jump.
REQ-007 SHALL have port cond_code  input  3  jump condition selector.
REQ-008 SHALL have port flags  input  4  ALU flags: [0]=Z, [1]=C, [2]=N, [3]=V.
REQ-009 SHALL have port jmp_target  input  ADDR_W  jump destination address.
REQ-010 SHALL have port hold_in  input  1  hold status from the conditional-jump hold counter.
REQ-011 SHALL have port cjmp_req  output  1  one-cycle request pulse that arms the hold counter.
REQ-012 SHALL have port fetch_en  output  1  instruction fetch enable.
REQ-013 SHALL have port pc_load  output  1  one-cycle PC load strobe.
REQ-014 SHALL have port pc_target  output  ADDR_W  PC value accompanying pc_load.
REQ-015 SHALL have port flush  output  1  one-cycle pipeline flush strobe.
REQ-016 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-017 SHALL have port hold_err  output  1  sticky flag set when hold_in fails to assert within HOLD_TIMEOUT.

Function
REQ-018 SHALL implement the FSM states IDLE, REQ, WAIT and RESOLVE, with registered state and registered outputs.
REQ-019 In IDLE, when instr_valid and instr_is_cjmp are both high, SHALL latch jmp_target, latch taken = eval(cond_code, flags), and go to REQ on the next edge.
REQ-020 eval SHALL decode cond_code as: 0 always, 1 Z, 2 !Z, 3 C, 4 !C, 5 N, 6 !N, 7 V.
REQ-021 Flags SHALL be sampled only at acceptance; later flag changes SHALL NOT affect taken.
REQ-022 In IDLE, instr_valid with instr_is_cjmp low SHALL be ignored, and fetch_en SHALL remain 1.
REQ-023 In REQ, cjmp_req SHALL be 1 for exactly one cycle, fetch_en SHALL be 0, and the FSM SHALL go to WAIT.
REQ-024 In WAIT, fetch_en SHALL be 0 and a saturating counter SHALL track cycles until hold_in is seen high (seen_hold).
REQ-025 In WAIT, once seen_hold is set and hold_in is low, the FSM SHALL go to RESOLVE.
REQ-026 In WAIT, if hold_in is not seen high within HOLD_TIMEOUT cycles, SHALL set hold_err and go to RESOLVE.
REQ-027 In RESOLVE, if taken: pc_load=1, flush=1, pc_target=latched target, all for one cycle; if not taken: pc_load=0 and flush=0.
REQ-028 RESOLVE SHALL return to IDLE on the next edge; fetch_en SHALL be 1 from that IDLE cycle onward.
REQ-029 A cjmp presented while busy SHALL be ignored; upstream is stalled by fetch_en=0.
REQ-030 Total latency from acceptance to pc_load SHALL be 2 + (cycles in WAIT) + 1 clocks; with a 2-cycle hold this is 5 clocks.
REQ-031 pc_target SHALL hold its last latched value outside RESOLVE.

Reset
REQ-032 Asserting reset at any time, including mid-sequence, SHALL immediately force: state=IDLE, fetch_en=1, cjmp_req=0, pc_load=0, flush=0, busy=0, hold_err=0, pc_target=0, taken=0, counters=0.
REQ-033 After reset deasserts, the first rising edge SHALL behave as IDLE, and no pending jump SHALL be resumed.

Structure
REQ-034 State encodings and cond_code constants SHALL reside in shared package uc_pkg.
REQ-035 Condition evaluation SHALL be a sub-module uc_cond_eval (combinational: cond_code, flags -> taken); the FSM stays in uc_cjmp_issue.

Verification
REQ-036 Taken jump: cond=1, Z=1, target=0x3C, hold_in high for 2 cycles after the cjmp_req cycle -> cjmp_req 1 cycle, pc_load and flush 1 cycle with pc_target=0x3C, 5 clocks after acceptance.
REQ-037 Not-taken jump: cond=2, Z=1, normal hold -> no pc_load, no flush, fetch_en returns to 1 after RESOLVE.
REQ-038 Flag change after acceptance: cond=3, C=1 at acceptance, C=0 during WAIT -> jump still taken.
REQ-039 Missing hold: hold_in tied low -> hold_err=1 after 4 WAIT cycles, then RESOLVE, then IDLE.
REQ-040 Reset mid-WAIT: reset pulsed during WAIT -> all outputs at reset values immediately, no pc_load afterwards.
REQ-041 Back-to-back: second cjmp presented while busy -> ignored; a cjmp presented in the first IDLE cycle after RESOLVE -> accepted.
